// File: rtl/bmem_pkg.sv
// Shared types and sizing for the burst-memory line arbiter.
// A 256-bit line moves as four 64-bit beats on the bmem port.
package bmem_pkg;
    localparam int BEAT_WIDTH       = 64;
    localparam int BURST_LEN        = 4;
    localparam int LINE_WIDTH       = BEAT_WIDTH * BURST_LEN;
    localparam int LINE_BYTES       = LINE_WIDTH / 8;

    typedef logic [LINE_WIDTH-1:0]                  line_t;
    typedef logic [BURST_LEN-1:0][BEAT_WIDTH-1:0]   line_beats_t;
    typedef logic [$clog2(BURST_LEN)-1:0]           beat_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        RESP
    } bmem_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant.
// Produces both a one-hot and an encoded grant.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);
    logic [IW-1:0] idx;

    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = last_grant;
        // Walk the ring starting just after the previous winner; first hit wins.
        for (int i = 0; i < N; i++) begin
            idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/bmem_line_arbiter.sv
// Shares one banked burst-memory port between cache-line requesters,
// serializing line writes into beats and reassembling read bursts into lines.
module bmem_line_arbiter
    import bmem_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr  [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]  req_read,
    input  logic [NUM_PORTS-1:0]  req_write,
    input  line_t                 req_wdata [NUM_PORTS],
    output line_t                 req_rdata [NUM_PORTS],
    output logic [NUM_PORTS-1:0]  req_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    bmem_arb_state_t       state_q, state_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    line_beats_t           line_q, line_d;
    beat_idx_t             beat_q, beat_d;

    logic [NUM_PORTS-1:0]  arb_oh;
    logic [IW-1:0]         arb_idx;
    logic                  arb_valid;

    rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
        .req         (req_read | req_write),
        .last_grant  (last_grant_q),
        .grant_oh    (arb_oh),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        line_d       = line_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    last_grant_d = arb_idx;
                    addr_d       = req_addr[arb_idx] & ADDR_MASK;
                    line_d       = line_beats_t'(req_wdata[arb_idx]);
                    beat_d       = '0;
                    state_d      = (|(req_write & arb_oh)) ? WR : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    beat_d  = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Beats tagged for another burst belong to someone else; drop them.
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    line_d[beat_q] = bmem_rdata;
                    beat_d         = beat_q + 1'b1;
                    if (beat_q == beat_idx_t'(BURST_LEN - 1)) begin
                        state_d = RESP;
                    end
                end
            end
            WR: begin
                if (bmem_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == beat_idx_t'(BURST_LEN - 1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_PORTS - 1);
            addr_q       <= '0;
            line_q       <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            beat_q       <= beat_d;
        end
    end

    // Outputs decode only registered state, so nothing from req_* reaches bmem_*.
    assign bmem_read  = (state_q == RD_REQ);
    assign bmem_write = (state_q == WR);
    assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
    assign bmem_wdata = bmem_write ? line_q[beat_q] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign req_resp[gi]  = (state_q == RESP) && (last_grant_q == IW'(gi));
            assign req_rdata[gi] = req_resp[gi] ? line_t'(line_q) : '0;

            a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
                !(req_read[gi] && req_write[gi]));
            a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
                (state_q != IDLE && last_grant_q == IW'(gi)) |-> (req_read[gi] || req_write[gi]));
        end
    endgenerate
endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: a vector table of line transactions
// plus hand-written fairness, filtering and mid-burst reset sequences.
module tb_bmem_line_arbiter;
    import bmem_pkg::*;

    localparam int NP = 2;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   req_addr  [NP];
    logic [NP-1:0]   req_read;
    logic [NP-1:0]   req_write;
    line_t           req_wdata [NP];
    line_t           req_rdata [NP];
    logic [NP-1:0]   req_resp;
    logic [AW-1:0]   bmem_addr;
    logic            bmem_read;
    logic            bmem_write;
    logic [63:0]     bmem_wdata;
    logic            bmem_ready;
    logic [AW-1:0]   bmem_raddr;
    logic [63:0]     bmem_rdata;
    logic            bmem_rvalid;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        line_t       line;
        int          stall_beat;
        int          stall_cyc;
        bit          bad_beat;
    } vec_t;

    vec_t vecs [5];

    bmem_line_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_addr   (req_addr),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_rdata  (req_rdata),
        .req_resp   (req_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Entered #1 after the grant edge. pre = cycles bmem_ready stays low in RD_REQ.
    task automatic serve_read(input int p, input logic [31:0] ea, input line_t line,
                              input int pre, input bit bad);
        for (int s = 0; s < pre; s++) begin
            bmem_ready = 1'b0;
            @(negedge clk);
            check("rd_hold", bmem_read, 1);
            @(posedge clk); #1;
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        check("rd_req", bmem_read, 1);
        check("rd_addr", bmem_addr, ea);
        @(posedge clk); #1;
        bmem_ready = 1'b0;
        if (bad) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'hDEAD_0000;
            bmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
            @(negedge clk);
            check("rd_bad_noresp", req_resp, 0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = ea;
            bmem_rdata  = line[64*k +: 64];
            @(negedge clk);
            check("rd_beat_idle_bus", {bmem_read, req_resp}, 0);
            @(posedge clk); #1;
        end
        bmem_rvalid = 1'b0;
        @(negedge clk);
        check("rd_resp", req_resp, 1 << p);
        check("rd_data", req_rdata[p], line);
        check("rd_other_zero", req_rdata[1-p], 0);
        @(posedge clk); #1;
        check("rd_resp_pulse", req_resp, 0);
    endtask

    // Entered #1 after the grant edge; ready is held low for sc cycles before beat sb.
    task automatic serve_write(input int p, input logic [31:0] ea, input line_t line,
                               input int sb, input int sc);
        for (int k = 0; k < 4; k++) begin
            if (k == sb) begin
                for (int s = 0; s < sc; s++) begin
                    bmem_ready = 1'b0;
                    @(negedge clk);
                    check("wr_stall_valid", bmem_write, 1);
                    check("wr_stall_data", bmem_wdata, line[64*k +: 64]);
                    @(posedge clk); #1;
                end
            end
            bmem_ready = 1'b1;
            @(negedge clk);
            check("wr_valid", {bmem_write, req_resp}, 4);
            check("wr_addr", bmem_addr, ea);
            check("wr_data", bmem_wdata, line[64*k +: 64]);
            @(posedge clk); #1;
        end
        bmem_ready = 1'b0;
        @(negedge clk);
        check("wr_resp", req_resp, 1 << p);
        check("wr_done", bmem_write, 0);
        @(posedge clk); #1;
    endtask

    // Called #1 after an edge with the arbiter in IDLE.
    task automatic run_txn(input vec_t v);
        req_addr[v.port]  = v.addr;
        req_wdata[v.port] = v.line;
        if (v.wr) req_write[v.port] = 1'b1;
        else      req_read[v.port]  = 1'b1;
        @(posedge clk); #1;
        if (v.wr) serve_write(v.port, v.exp_addr, v.line, v.stall_beat, v.stall_cyc);
        else      serve_read(v.port, v.exp_addr, v.line, v.stall_cyc, v.bad_beat);
        req_read[v.port]  = 1'b0;
        req_write[v.port] = 1'b0;
    endtask

    line_t la, lb, lw;

    initial begin
        la = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
        lb = {64'hB4B4_0000_0000_0004, 64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002, 64'hB1B1_0000_0000_0001};
        lw = {64'hC3C3_C3C3_0000_0003, 64'hC2C2_C2C2_0000_0002, 64'hC1C1_C1C1_0000_0001, 64'hC0C0_C0C0_0000_0000};

        vecs[0] = '{0, 1'b0, 32'h0000_1234, 32'h0000_1220,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, -1, 2, 1'b1};
        vecs[1] = '{1, 1'b1, 32'h8000_0040, 32'h8000_0040, lw, 2, 3, 1'b0};
        vecs[2] = '{1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                    {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                     64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000}, -1, 0, 1'b0};
        vecs[3] = '{0, 1'b1, 32'h0000_001F, 32'h0000_0000,
                    {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
                     64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000}, -1, 0, 1'b0};
        vecs[4] = '{0, 1'b0, 32'h1234_5660, 32'h1234_5660, lb, -1, 1, 1'b0};

        req_read    = '0;
        req_write   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        for (int i = 0; i < NP; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bus", {bmem_read, bmem_write, bmem_addr, bmem_wdata}, 0);
        check("reset_resp", req_resp, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Simultaneous requests right after reset: port 0, then port 1, twice.
        for (int r = 0; r < 2; r++) begin
            req_addr[0] = 32'h0000_2000 + 32'(r * 32'h100);
            req_addr[1] = 32'h0000_3008 + 32'(r * 32'h100);
            req_read    = 2'b11;
            @(posedge clk); #1;
            serve_read(0, 32'h0000_2000 + 32'(r * 32'h100), la, 0, 1'b0);
            $display("fair round %0d: first grant port 0 served", r);
            req_read[0] = 1'b0;
            @(posedge clk); #1;
            serve_read(1, 32'h0000_3000 + 32'(r * 32'h100), lb, 0, 1'b0);
            $display("fair round %0d: second grant port 1 served", r);
            req_read[1] = 1'b0;
        end

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
            $display("txn %0d: port %0d %s addr %h -> bmem %h", i, vecs[i].port,
                     vecs[i].wr ? "write" : "read", vecs[i].addr, vecs[i].exp_addr);
        end

        // rvalid while IDLE must not be captured into the next line.
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_1220;
        bmem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("idle_rvalid_noresp", {bmem_read, req_resp}, 0);
            @(posedge clk); #1;
        end
        bmem_rvalid = 1'b0;
        run_txn(vecs[0]);
        $display("txn idle-filter: port 0 read after stray rvalid");

        // Reset in the middle of a write burst, after beat 1 is accepted.
        req_addr[1]  = 32'h8000_0040;
        req_wdata[1] = lw;
        req_write[1] = 1'b1;
        @(posedge clk); #1;
        bmem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_wr_beat2", bmem_wdata, lw[191:128]);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_bus", {bmem_read, bmem_write, bmem_addr, bmem_wdata}, 0);
        check("async_rst_resp", req_resp, 0);
        check("async_rst_rdata", {req_rdata[0], req_rdata[1]}, 0);
        req_write[1] = 1'b0;
        bmem_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("held_rst_bus", {bmem_read, bmem_write}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn('{1, 1'b0, 32'h0000_4444, 32'h0000_4440, la, -1, 0, 1'b0});
        $display("txn post-reset: port 1 read addr 00004444 -> bmem 00004440");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
